// File: rtl/vram_arbiter.sv
// Video RAM port arbiter: VGA tile fetch has absolute priority, the CPU gets the
// single synchronous RAM port only in cycles where VGA is not fetching.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 1024,
  parameter int unsigned CNT_W        = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  // VGA fetch path
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  // CPU request/ack interface
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_grant,
  output logic              cpu_starved,
  // RAM macro port
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StAck
  } state_e;

  localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              cpu_starved_q, cpu_starved_d;

  // Port mux: VGA always wins; the CPU is only issued from IDLE, so a request
  // held through RD_WAIT/ACK is never issued twice.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    cpu_grant = 1'b0;
    if (vga_req) begin
      ram_addr = vga_addr;
    end else if (state_q == StIdle && cpu_req) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      cpu_grant = 1'b1;
    end
  end

  assign ram_wdata = cpu_wdata;
  assign vga_rdata = ram_q;

  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_grant) begin
          state_d = cpu_we ? StAck : StRdWait;
        end
      end
      StRdWait: begin
        // ram_q now carries the data for the CPU address issued last cycle.
        cpu_rdata_d = ram_q;
        state_d     = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cpu_ack_d = (state_d == StAck);

  // Starvation tracking: counts IDLE cycles lost to VGA, saturating at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (cpu_grant) begin
      wait_cnt_d = '0;
    end else if (state_q == StIdle && cpu_req && vga_req && wait_cnt_q != StarveLimit) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign cpu_starved_d = cpu_starved_q | (wait_cnt_d == StarveLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      wait_cnt_q    <= '0;
      cpu_starved_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
      cpu_starved_q <= cpu_starved_d;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_starved = cpu_starved_q;

endmodule
